// File: rtl/ethernet_pkg.sv
// Shared Ethernet receive constants and state encoding.
// Imported by the RX frame controller and its preamble counter.
package ethernet_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_FRAME    = 3'd2;
    localparam logic [2:0] ST_DROP     = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] ETH_SFD_BYTE      = 8'hD5;

    localparam int ETH_MIN_FRAME = 64;
    localparam int ETH_MAX_FRAME = 1518;

endpackage

// File: rtl/ethernet_preamble_counter.sv
// Preamble hunt: counts 0x55 bytes and flags a good or bad SFD.
// Ports: clk, reset_n, clear (restart count), en, byte_ready, rx_byte -> sfd_ok, sfd_bad.
module ethernet_preamble_counter
    import ethernet_pkg::*;
#(
    parameter int MIN_PREAMBLE = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       en,
    input  logic       byte_ready,
    input  logic [7:0] rx_byte,
    output logic       sfd_ok,
    output logic       sfd_bad
);

    localparam int CW = $clog2(MIN_PREAMBLE + 1);
    localparam logic [CW-1:0] CNT_MIN = CW'(MIN_PREAMBLE);

    logic [CW-1:0] cnt;
    logic [CW-1:0] base;
    logic [CW-1:0] cnt_d;
    logic          strobe;
    logic          is_pre;
    logic          is_sfd;
    logic          enough;

    // clear acts on the same cycle so a byte strobed on entry counts from zero
    always_comb begin
        base   = clear ? '0 : cnt;
        strobe = en & byte_ready;
        is_pre = (rx_byte == ETH_PREAMBLE_BYTE);
        is_sfd = (rx_byte == ETH_SFD_BYTE);
        enough = (base >= CNT_MIN);
        cnt_d  = base;
        if (strobe && is_pre && !enough) begin
            cnt_d = base + CW'(1);
        end
        sfd_ok  = strobe & is_sfd & enough;
        sfd_bad = strobe & ~is_pre & ~(is_sfd & enough);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/ethernet_rx_frame_controller.sv
// Ethernet RX sequencer: preamble/SFD hunt, byte forwarding, length check.
// Ports: rx_active/byte_ready/rx_byte in; out_valid/out_data/out_sof/out_ready
// downstream; frame_done/frame_ok/err_*/len status; busy when not idle.
module ethernet_rx_frame_controller
    import ethernet_pkg::*;
#(
    parameter int MIN_PREAMBLE = 7,
    parameter int MIN_FRAME    = ETH_MIN_FRAME,
    parameter int MAX_FRAME    = ETH_MAX_FRAME,
    parameter int LEN_W        = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx_active,
    input  logic             byte_ready,
    input  logic [7:0]       rx_byte,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_sof,
    input  logic             out_ready,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             err_short,
    output logic             err_long,
    output logic             err_overflow,
    output logic [LEN_W-1:0] len,
    output logic             busy
);

    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_FRAME);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FRAME);
    localparam logic [LEN_W-1:0] LEN_CAP = LEN_W'(MAX_FRAME + 1);

    logic [2:0] state;
    logic [2:0] state_d;
    logic       pre_en;
    logic       pre_clear;
    logic       sfd_ok;
    logic       sfd_bad;
    logic       fwd;
    logic       sof_pend;
    logic       ovf;
    logic       ovf_now;

    // IDLE evaluates a same-cycle byte as if already in PREAMBLE
    assign pre_clear = (state == ST_IDLE);
    assign pre_en    = rx_active &
                       ((state == ST_IDLE) | (state == ST_PREAMBLE));
    assign fwd       = (state == ST_FRAME) & byte_ready;

    ethernet_preamble_counter #(
        .MIN_PREAMBLE(MIN_PREAMBLE)
    ) u_pre (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (pre_clear),
        .en        (pre_en),
        .byte_ready(byte_ready),
        .rx_byte   (rx_byte),
        .sfd_ok    (sfd_ok),
        .sfd_bad   (sfd_bad)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: begin
                if (rx_active) begin
                    if (sfd_ok) begin
                        state_d = ST_FRAME;
                    end else if (sfd_bad) begin
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_PREAMBLE;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!rx_active) begin
                    state_d = ST_IDLE;
                end else if (sfd_ok) begin
                    state_d = ST_FRAME;
                end else if (sfd_bad) begin
                    state_d = ST_DROP;
                end
            end
            ST_FRAME: begin
                if (!rx_active) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = rx_active ? ST_DROP : ST_IDLE;
            end
            ST_DROP: begin
                if (!rx_active) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: registered byte forward, length and overflow tracking.
    // len/ovf are cleared on SFD so an empty frame reports zero length.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            sof_pend  <= 1'b0;
            len       <= '0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= fwd;
            out_sof   <= fwd & sof_pend;
            if (fwd) begin
                out_data <= rx_byte;
            end
            if (sfd_ok) begin
                sof_pend <= 1'b1;
                len      <= '0;
                ovf      <= 1'b0;
            end else begin
                if (fwd) begin
                    sof_pend <= 1'b0;
                    if (len != LEN_CAP) begin
                        len <= len + LEN_W'(1);
                    end
                end
                if (out_valid && !out_ready) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    // The last byte may still be on the output during DONE
    always_comb begin
        ovf_now      = ovf | (out_valid & ~out_ready);
        frame_done   = (state == ST_DONE);
        err_short    = frame_done & (len < LEN_MIN);
        err_long     = frame_done & (len > LEN_MAX);
        err_overflow = frame_done & ovf_now;
        frame_ok     = frame_done & ~(err_short | err_long | err_overflow);
        busy         = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_ethernet_rx_frame_controller.sv
// Self-checking bench for ethernet_rx_frame_controller.
// Directed frame table, reset corner case and randomized frames.
module tb_ethernet_rx_frame_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_active;
    logic        byte_ready;
    logic [7:0]  rx_byte;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_ready;
    logic        frame_done;
    logic        frame_ok;
    logic        err_short;
    logic        err_long;
    logic        err_overflow;
    logic [10:0] len;
    logic        busy;

    always #5 clk = ~clk;

    ethernet_rx_frame_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_active   (rx_active),
        .byte_ready  (byte_ready),
        .rx_byte     (rx_byte),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sof     (out_sof),
        .out_ready   (out_ready),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .err_short   (err_short),
        .err_long    (err_long),
        .err_overflow(err_overflow),
        .len         (len),
        .busy        (busy)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int sof_cnt, sof_bad, done_cnt;
    int d_len, d_ok, d_short, d_long, d_ovf;

    typedef struct {
        int         pre;
        logic [7:0] sfd;
        int         n;
        int         stall;
        bit         ed;
        int         el;
        bit         eok;
        bit         es;
        bit         elg;
        bit         eov;
    } vec_t;

    vec_t vt[10];

    task automatic chk(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Sampled mid-cycle, after the driver has settled this cycle's inputs
    always @(negedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            if (out_sof !== (got_q.size() == 0)) sof_bad++;
            if (out_sof === 1'b1) sof_cnt++;
            got_q.push_back(out_data);
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            d_len   = int'(len);
            d_ok    = int'(frame_ok);
            d_short = int'(err_short);
            d_long  = int'(err_long);
            d_ovf   = int'(err_overflow);
        end
    end

    task automatic cyc(logic act, logic br, logic [7:0] b, logic rdy);
        @(negedge clk);
        rx_active  = act;
        byte_ready = br;
        rx_byte    = b;
        out_ready  = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        sof_cnt  = 0;
        sof_bad  = 0;
        done_cnt = 0;
    endtask

    task automatic run_frame(string t, int pre, logic [7:0] sfd, int n,
                             int stall, bit rnd, bit gaps, bit fl, bit ed);
        bit st;
        logic [7:0] b;
        st = 0;
        clear_mon();
        cyc(1, 0, 8'h00, 1);
        for (int i = 0; i < pre; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) cyc(1, 0, 8'h00, 1);
            cyc(1, 1, 8'h55, 1);
        end
        cyc(1, 1, sfd, 1);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                cyc(1, 0, 8'h00, !st);
                st = 0;
            end
            b = rnd ? 8'($urandom) : 8'(i);
            exp_q.push_back(b);
            if (fl && i == n - 1) cyc(0, 1, b, !st);
            else cyc(1, 1, b, !st);
            st = (i == stall);
        end
        if (!fl) begin
            cyc(0, 0, 8'h00, !st);
            st = 0;
        end
        chk({t, ".busy_after_fall"}, int'(busy), int'(ed));
        cyc(0, 0, 8'h00, !st);
        cyc(0, 0, 8'h00, 1);
        chk({t, ".busy_idle"}, int'(busy), 0);
    endtask

    task automatic check_frame(string t, bit ed, int el, bit eok,
                               bit es, bit elg, bit eov);
        int nm;
        chk({t, ".done"}, done_cnt, ed ? 1 : 0);
        chk({t, ".bytes"}, got_q.size(), ed ? exp_q.size() : 0);
        if (ed) begin
            chk({t, ".len"}, d_len, el);
            chk({t, ".ok"}, d_ok, int'(eok));
            chk({t, ".short"}, d_short, int'(es));
            chk({t, ".long"}, d_long, int'(elg));
            chk({t, ".ovf"}, d_ovf, int'(eov));
            chk({t, ".sof"}, sof_cnt, 1);
            chk({t, ".sof_pos"}, sof_bad, 0);
            nm = 0;
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                if (got_q[i] !== exp_q[i]) nm++;
            end
            chk({t, ".data_mismatches"}, nm, 0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int pre, n, stall, el;
        logic [7:0] sfd;
        bit fl, ed, es, elg, eov, eok;

        vt[0] = '{7,  8'hD5, 64,   -1, 1, 64,   1, 0, 0, 0};
        vt[1] = '{6,  8'hD5, 64,   -1, 0, 0,    0, 0, 0, 0};
        vt[2] = '{7,  8'hD5, 20,   -1, 1, 20,   0, 1, 0, 0};
        vt[3] = '{7,  8'hD5, 1600, -1, 1, 1519, 0, 0, 1, 0};
        vt[4] = '{7,  8'hD5, 100,  10, 1, 100,  0, 0, 0, 1};
        vt[5] = '{10, 8'hD5, 1518, -1, 1, 1518, 1, 0, 0, 0};
        vt[6] = '{7,  8'hD5, 63,   -1, 1, 63,   0, 1, 0, 0};
        vt[7] = '{7,  8'hD5, 1519, -1, 1, 1519, 0, 0, 1, 0};
        vt[8] = '{8,  8'h57, 64,   -1, 0, 0,    0, 0, 0, 0};
        vt[9] = '{7,  8'hD5, 64,   63, 1, 64,   0, 0, 0, 1};

        reset_n    = 1'b0;
        rx_active  = 1'b0;
        byte_ready = 1'b0;
        rx_byte    = 8'h00;
        out_ready  = 1'b1;
        clear_mon();
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 1);
        chk("reset.out_valid", int'(out_valid), 0);
        chk("reset.frame_done", int'(frame_done), 0);
        chk("reset.len", int'(len), 0);
        chk("reset.busy", int'(busy), 0);
        reset_n = 1'b1;
        cyc(0, 0, 8'h00, 1);

        for (int k = 0; k < 10; k++) begin
            run_frame($sformatf("vec%0d", k), vt[k].pre, vt[k].sfd, vt[k].n,
                      vt[k].stall, 0, 0, 0, vt[k].ed);
            check_frame($sformatf("vec%0d", k), vt[k].ed, vt[k].el,
                        vt[k].eok, vt[k].es, vt[k].elg, vt[k].eov);
        end

        // Reset in the middle of a frame abandons it silently
        clear_mon();
        cyc(1, 0, 8'h00, 1);
        for (int i = 0; i < 7; i++) cyc(1, 1, 8'h55, 1);
        cyc(1, 1, 8'hD5, 1);
        for (int i = 0; i < 30; i++) cyc(1, 1, 8'(i), 1);
        @(negedge clk);
        reset_n    = 1'b0;
        rx_active  = 1'b0;
        byte_ready = 1'b1;
        rx_byte    = 8'hAA;
        @(posedge clk);
        #2;
        chk("mid_reset.out_valid", int'(out_valid), 0);
        chk("mid_reset.out_sof", int'(out_sof), 0);
        chk("mid_reset.out_data", int'(out_data), 0);
        chk("mid_reset.frame_done", int'(frame_done), 0);
        chk("mid_reset.errs", int'({frame_ok, err_short, err_long, err_overflow}), 0);
        chk("mid_reset.len", int'(len), 0);
        chk("mid_reset.busy", int'(busy), 0);
        reset_n = 1'b1;
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 1);
        chk("mid_reset.no_done", done_cnt, 0);
        run_frame("after_reset", 7, 8'hD5, 64, -1, 0, 0, 0, 1);
        check_frame("after_reset", 1, 64, 1, 0, 0, 0);

        // Randomized frames against a rule-level model
        for (int k = 0; k < 30; k++) begin
            pre   = $urandom_range(5, 9);
            sfd   = ($urandom_range(0, 9) == 0) ? 8'h5D : 8'hD5;
            n     = ($urandom_range(0, 9) == 0) ? $urandom_range(1500, 1530)
                                                 : $urandom_range(1, 150);
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            fl    = 1'($urandom_range(0, 1));
            ed    = (pre >= 7) && (sfd == 8'hD5);
            el    = (n > 1519) ? 1519 : n;
            es    = (el < 64);
            elg   = (n > 1518);
            eov   = (stall >= 0);
            eok   = !(es || elg || eov);
            run_frame($sformatf("rnd%0d", k), pre, sfd, n, stall, 1, 1, fl, ed);
            check_frame($sformatf("rnd%0d", k), ed, el, eok, es, elg, eov);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
